alu_exec: RTL and testbench
===========================

# alu_exec

Multi-cycle ALU execution unit that consumes the 6-bit ALU control code produced by the ALU control decoder, together with two operands. It performs the selected operation and returns a registered result with zero, overflow and illegal-op flags. It sits in the execute stage of the unpipelined core, between the decoder/operand mux and writeback. Both sides use valid/ready handshakes, so iterative shifts can stall the core.

## Interface

Parameters:
- `DATA_W`, default 32: operand and result width. The shift amount width is `SH_W = $clog2(DATA_W)`.

Ports:
- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: asynchronous reset, active-low.
- `i_valid`, input, 1: operation request.
- `o_ready`, output, 1: the unit can accept a request this cycle.
- `i_aluControl`, input, 6: operation code (values below).
- `i_op1`, input, DATA_W: operand 1. For shifts, this is the shift amount (`i_op1[SH_W-1:0]`); the decoder has already muxed shamt in.
- `i_op2`, input, DATA_W: operand 2. For shifts, this is the data being shifted.
- `o_valid`, output, 1: result available.
- `i_ready`, input, 1: consumer accepts the result.
- `o_result`, output, DATA_W: registered result.
- `o_zero`, output, 1: `o_result == 0`.
- `o_ovf`, output, 1: signed overflow (ADD/SUB only).
- `o_illegal`, output, 1: the operation code was unrecognised.

## Operation

Operation codes (hex) and results:
- 20 ADD, 21 ADDU: op1+op2.
- 22 SUB, 23 SUBU: op1−op2.
- 24 AND, 25 OR, 26 XOR, 27 NOR: bitwise on op1, op2.
- 2A SLT: signed op1<op2 gives 1, else 0. 2B SLTU: same, unsigned.
- 00 SLL / 04 SLLV: op2 << amt.
- 02 SRL / 06 SRLV: op2 >> amt, logical.
- 03 SRA / 07 SRAV: op2 >> amt, arithmetic.
- 3E ROTR / 3F ROTRV: op2 rotated right by amt.
- 08 JR: result = op1 (passthrough).
- 3C LUI: result = {op2[DATA_W/2-1:0], DATA_W/2 zeros}.
- Any other code: result 0, `o_illegal`=1.

Flags:
- `o_ovf`=1 only for ADD/SUB on two's-complement overflow; the result is still written. ADDU/SUBU never set it.
- `o_zero` and `o_illegal` are registered with `o_result`.

FSM, with states IDLE, SHIFT and DONE:
- IDLE: `o_ready`=1. On `i_valid`:
  - Iterative shift with amt≠0: latch op2 into the shift register and amt into the counter, then go to SHIFT.
  - Anything else: compute, register the result and flags, then go to DONE.
- SHIFT: `o_ready`=0. Each cycle shifts or rotates by one bit and decrements the counter. On the cycle the counter reaches 0, register the result and go to DONE.
  - SRA fills with the original sign bit.
  - ROTR feeds bit 0 into the MSB.
- DONE: `o_valid`=1, with `o_result` and flags held stable until `i_ready`.
  - `o_ready` = `i_ready`. A handshake on both sides in the same cycle starts the new operation; otherwise go to IDLE.
- Inputs are sampled only on the accepting edge. Changes to `i_aluControl`/`i_op*` while not ready are ignored.

## Timing

- Reset (async, `i_rst_n`=0): state IDLE, `o_valid`=0, `o_result`=0, `o_zero`=1, `o_ovf`=0, `o_illegal`=0, counter 0. `o_ready`=1 as soon as reset deasserts.
- Reset asserted mid-SHIFT or in DONE aborts the operation; the result is lost.
- Latency runs from the accepting edge to `o_valid`=1:
  - Non-shift ops, and shifts with amt=0: 1 cycle.
  - Iterative shift with amt=n: n cycles (worst case DATA_W−1).
- Throughput: back-to-back single-cycle ops sustain one per cycle while `i_ready`=1.
- `o_valid` falls the cycle after a handshake unless a new op was accepted on that same edge.

## Configuration

- `ALU_BARREL_SHIFT_EN` defined: all shifts and rotates are computed combinationally in IDLE with 1-cycle latency; the SHIFT state and counter are not built.
- Undefined (default): shifts with amt≠0 iterate at one bit per cycle as described above.
- Results are bit-identical in both builds; only latency differs.

## Test plan

- Reset then ADD: op1=7FFFFFFF, op2=1 gives result 80000000, `o_ovf`=1, `o_zero`=0, `o_valid` 1 cycle after accept. ADDU on the same operands gives `o_ovf`=0.
- SUB with op1=5, op2=5 gives result 0 and `o_zero`=1. SLT with op1=FFFFFFFF, op2=1 gives 1. SLTU on the same operands gives 0.
- SRA with op1=4, op2=80000010 gives F8000001. Without the macro: `o_valid` exactly 4 cycles after accept and `o_ready`=0 meanwhile. With the macro: 1 cycle.
- ROTRV with amt=31, op2=00000001 gives 00000002 after 31 cycles. Also cover amt=0 (1 cycle, result = op2) and LUI with op2=0000ABCD giving ABCD0000.
- Backpressure: hold `i_ready`=0 for 5 cycles in DONE, checking result, flags and `o_valid` stay stable and new `i_valid` is ignored. Then raise `i_ready` with `i_valid` (AND F0F0, 0FF0) and check the next result 00F0 appears on the following cycle.
- Code 3A gives result 0 and `o_illegal`=1. Pulse `i_rst_n` low mid-SHIFT and check `o_valid`=0 immediately, then IDLE and `o_ready`=1 after release.

Source files
------------

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - multi-cycle ALU execute unit with valid/ready on both sides (optional ALU_BARREL_SHIFT_EN)
module alu_exec #(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [5:0]        i_aluControl,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_ovf,
    output logic              o_illegal
);
    localparam int SH_W = $clog2(DATA_W);

    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;
    localparam logic [1:0] K_ROT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic              illegal_q, illegal_d;

    logic              accept;
    logic              go_shift;
    logic [SH_W-1:0]   amt;
    logic [DATA_W-1:0] sum, diff;
    logic [DATA_W-1:0] op_result;
    logic              op_ovf, op_illegal, op_is_shift;
    logic [1:0]        op_kind;

    // Move a value by exactly one bit position; SRA replicates the sign bit, ROTR wraps bit 0 to the MSB.
    function automatic logic [DATA_W-1:0] shift_one(input logic [1:0] k, input logic [DATA_W-1:0] v);
        case (k)
            K_SLL:   shift_one = {v[DATA_W-2:0], 1'b0};
            K_SRL:   shift_one = {1'b0, v[DATA_W-1:1]};
            K_SRA:   shift_one = {v[DATA_W-1], v[DATA_W-1:1]};
            default: shift_one = {v[0], v[DATA_W-1:1]};
        endcase
    endfunction

`ifdef ALU_BARREL_SHIFT_EN
    // Full-distance shift or rotate in one pass.
    function automatic logic [DATA_W-1:0] barrel(input logic [1:0] k, input logic [DATA_W-1:0] v,
                                                 input logic [SH_W-1:0] n);
        case (k)
            K_SLL:   barrel = v << n;
            K_SRL:   barrel = v >> n;
            K_SRA:   barrel = $unsigned($signed(v) >>> n);
            default: barrel = (v >> n) | (v << (DATA_W - int'(n)));
        endcase
    endfunction

    assign go_shift = 1'b0;
`else
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        kind_q, kind_d;

    // The first bit moves on the accepting edge, so an n-bit shift reports after n cycles.
    assign go_shift = op_is_shift && (amt > SH_W'(1));
`endif

    assign accept = i_valid && o_ready;

    // Decode the operation code and compute every single-cycle result and its flags.
    always_comb begin
        amt         = i_op1[SH_W-1:0];
        sum         = i_op1 + i_op2;
        diff        = i_op1 - i_op2;
        op_result   = '0;
        op_ovf      = 1'b0;
        op_illegal  = 1'b0;
        op_is_shift = 1'b0;
        op_kind     = K_SLL;
        case (i_aluControl)
            6'h20: begin
                op_result = sum;
                op_ovf    = (i_op1[DATA_W-1] == i_op2[DATA_W-1]) && (sum[DATA_W-1] != i_op1[DATA_W-1]);
            end
            6'h21: op_result = sum;
            6'h22: begin
                op_result = diff;
                op_ovf    = (i_op1[DATA_W-1] != i_op2[DATA_W-1]) && (diff[DATA_W-1] != i_op1[DATA_W-1]);
            end
            6'h23: op_result = diff;
            6'h24: op_result = i_op1 & i_op2;
            6'h25: op_result = i_op1 | i_op2;
            6'h26: op_result = i_op1 ^ i_op2;
            6'h27: op_result = ~(i_op1 | i_op2);
            6'h2A: op_result[0] = $signed(i_op1) < $signed(i_op2);
            6'h2B: op_result[0] = i_op1 < i_op2;
            6'h00, 6'h04: begin op_is_shift = 1'b1; op_kind = K_SLL; end
            6'h02, 6'h06: begin op_is_shift = 1'b1; op_kind = K_SRL; end
            6'h03, 6'h07: begin op_is_shift = 1'b1; op_kind = K_SRA; end
            6'h3E, 6'h3F: begin op_is_shift = 1'b1; op_kind = K_ROT; end
            6'h08: op_result = i_op1;
            6'h3C: op_result = {i_op2[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            default: op_illegal = 1'b1;
        endcase
        if (op_is_shift) begin
`ifdef ALU_BARREL_SHIFT_EN
            op_result = barrel(op_kind, i_op2, amt);
`else
            op_result = (amt == '0) ? i_op2 : shift_one(op_kind, i_op2);
`endif
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
`ifndef ALU_BARREL_SHIFT_EN
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
`endif
        if (accept) begin
            if (go_shift) begin
                state_d = S_SHIFT;
`ifndef ALU_BARREL_SHIFT_EN
                sh_d    = shift_one(op_kind, i_op2);
                cnt_d   = amt - 1'b1;
                kind_d  = op_kind;
`endif
            end else begin
                state_d   = S_DONE;
                result_d  = op_result;
                zero_d    = (op_result == '0);
                ovf_d     = op_ovf;
                illegal_d = op_illegal;
            end
        end else begin
            case (state_q)
`ifndef ALU_BARREL_SHIFT_EN
                S_SHIFT: begin
                    sh_d  = shift_one(kind_q, sh_q);
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == SH_W'(1)) begin
                        state_d   = S_DONE;
                        result_d  = sh_d;
                        zero_d    = (sh_d == '0);
                        ovf_d     = 1'b0;
                        illegal_d = 1'b0;
                    end
                end
`endif
                S_DONE: if (i_ready) state_d = S_IDLE;
                default: ;
            endcase
        end
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            sh_q      <= '0;
            cnt_q     <= '0;
            kind_q    <= K_SLL;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
`ifndef ALU_BARREL_SHIFT_EN
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
`endif
        end
    end

    // Handshake outputs decoded from the state; DONE passes downstream ready straight back upstream.
    always_comb begin
        o_valid = (state_q == S_DONE);
        o_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
    end

    assign o_result  = result_q;
    assign o_zero    = zero_q;
    assign o_ovf     = ovf_q;
    assign o_illegal = illegal_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec: vector table, corner sequences, randomized ops
module tb_alu_exec;
    localparam int W = 32;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit ITER = 1'b0;
`else
    localparam bit ITER = 1'b1;
`endif

    logic         i_clk, i_rst_n, i_valid, o_ready, o_valid, i_ready;
    logic         o_zero, o_ovf, o_illegal;
    logic [5:0]   i_aluControl;
    logic [W-1:0] i_op1, i_op2, o_result;

    int nerr = 0;
    int nchk = 0;

    alu_exec #(.DATA_W(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_aluControl(i_aluControl), .i_op1(i_op1), .i_op2(i_op2),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_zero(o_zero), .o_ovf(o_ovf), .o_illegal(o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [5:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         v;
        logic         il;
        int           lat;
    } vec_t;

    vec_t vt[17];

    logic [5:0] codes[22] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                              6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h3E, 6'h3F, 6'h08, 6'h3C,
                              6'h3A, 6'h11};

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference: results straight from the operation definitions using wide arithmetic.
    function automatic void ref_alu(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic v, output logic il,
                                    output int lat);
        int          n;
        longint      sa, sb, s;
        logic [63:0] t;
        n   = int'(a[4:0]);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = '0;
        v   = 1'b0;
        il  = 1'b0;
        lat = 1;
        case (c)
            6'h20: begin s = sa + sb; r = a + b; v = (s != longint'($signed(r))); end
            6'h21: r = a + b;
            6'h22: begin s = sa - sb; r = a - b; v = (s != longint'($signed(r))); end
            6'h23: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h26: r = a ^ b;
            6'h27: r = ~(a | b);
            6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: r = (a < b) ? 32'd1 : 32'd0;
            6'h00, 6'h04: r = b << n;
            6'h02, 6'h06: r = b >> n;
            6'h03, 6'h07: begin t = 64'(sb >>> n); r = t[31:0]; end
            6'h3E, 6'h3F: begin t = {b, b} >> n; r = t[31:0]; end
            6'h08: r = a;
            6'h3C: r = {b[15:0], 16'h0000};
            default: il = 1'b1;
        endcase
        case (c)
            6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h3E, 6'h3F:
                if (ITER && n != 0) lat = n;
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Issue one op, measure cycles from the accepting edge to o_valid, optionally stall the consumer.
    task automatic exec(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                        output logic [W-1:0] r, output logic v, output logic z, output logic il,
                        output int lat, output logic leak);
        int w;
        @(negedge i_clk);
        i_aluControl = c;
        i_op1        = a;
        i_op2        = b;
        i_valid      = 1'b1;
        i_ready      = 1'b1;
        w = 0;
        while (!o_ready && w < 100) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_ready) check("accept_timeout", o_ready, 1);
        @(posedge i_clk);
        #1;
        i_valid      = 1'b0;
        i_aluControl = 6'($urandom());
        i_op1        = $urandom();
        i_op2        = $urandom();
        lat  = 1;
        leak = 1'b0;
        while (!o_valid && lat < 100) begin
            if (o_ready) leak = 1'b1;
            @(posedge i_clk);
            #1;
            lat++;
        end
        r  = o_result;
        v  = o_ovf;
        z  = o_zero;
        il = o_illegal;
        if (hold > 0) begin
            i_ready = 1'b0;
            repeat (hold) begin
                @(posedge i_clk);
                #1;
            end
            check("hold_valid", o_valid, 1);
            check("hold_result", o_result, r);
            i_ready = 1'b1;
        end
    endtask

    initial begin
        logic [W-1:0] r, er;
        logic         v, z, il, leak, ev, eil;
        int           lat, elat;

        vt[0]  = '{6'h20, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1};
        vt[1]  = '{6'h21, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
        vt[2]  = '{6'h22, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1};
        vt[3]  = '{6'h2A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
        vt[4]  = '{6'h2B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1};
        vt[5]  = '{6'h03, 32'h00000004, 32'h80000010, 32'hF8000001, 1'b0, 1'b0, 4};
        vt[6]  = '{6'h3F, 32'h0000001F, 32'h00000001, 32'h00000002, 1'b0, 1'b0, 31};
        vt[7]  = '{6'h3E, 32'h00000000, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1};
        vt[8]  = '{6'h3C, 32'h00000000, 32'h0000ABCD, 32'hABCD0000, 1'b0, 1'b0, 1};
        vt[9]  = '{6'h3A, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1, 1};
        vt[10] = '{6'h23, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vt[11] = '{6'h22, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
        vt[12] = '{6'h27, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
        vt[13] = '{6'h00, 32'h00000001, 32'h80000001, 32'h00000002, 1'b0, 1'b0, 1};
        vt[14] = '{6'h08, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 1};
        vt[15] = '{6'h06, 32'h0000001F, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 31};
        vt[16] = '{6'h26, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0, 1'b0, 1};

        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_ready      = 1'b1;
        i_aluControl = 6'h00;
        i_op1        = '0;
        i_op2        = '0;
        repeat (2) @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_zero", o_zero, 1);
        check("rst_ovf", o_ovf, 0);
        check("rst_illegal", o_illegal, 0);
        i_rst_n = 1'b1;
        #1;
        check("rst_ready", o_ready, 1);

        for (int i = 0; i < 17; i++) begin
            exec(vt[i].c, vt[i].a, vt[i].b, 0, r, v, z, il, lat, leak);
            elat = ITER ? vt[i].lat : 1;
            check($sformatf("vec%0d_result", i), r, vt[i].r);
            check($sformatf("vec%0d_ovf", i), v, vt[i].v);
            check($sformatf("vec%0d_illegal", i), il, vt[i].il);
            check($sformatf("vec%0d_zero", i), z, (vt[i].r == 0));
            check($sformatf("vec%0d_latency", i), lat, elat);
            check($sformatf("vec%0d_ready_busy", i), leak, 0);
        end

        // Backpressure: result held for 5 stalled cycles, competing request ignored.
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_aluControl = 6'h20;
        i_op1        = 32'd1;
        i_op2        = 32'd2;
        i_valid      = 1'b1;
        i_ready      = 1'b0;
        @(posedge i_clk);
        #1;
        i_aluControl = 6'h22;
        i_op1        = 32'd9;
        i_op2        = 32'd2;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge i_clk);
                #1;
            end
            check($sformatf("bp%0d_valid", k), o_valid, 1);
            check($sformatf("bp%0d_result", k), o_result, 32'd3);
            check($sformatf("bp%0d_flags", k), {o_zero, o_ovf, o_illegal}, 3'b000);
            check($sformatf("bp%0d_ready", k), o_ready, 0);
        end
        @(negedge i_clk);
        i_aluControl = 6'h24;
        i_op1        = 32'h0000F0F0;
        i_op2        = 32'h00000FF0;
        i_ready      = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check("bp_next_valid", o_valid, 1);
        check("bp_next_result", o_result, 32'h000000F0);
        @(posedge i_clk);
        #1;
        check("bp_valid_falls", o_valid, 0);

        // Reset in the middle of an iterative shift discards it.
        @(negedge i_clk);
        i_aluControl = 6'h02;
        i_op1        = 32'd20;
        i_op2        = 32'hFFFF0000;
        i_valid      = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_result", o_result, 0);
        check("midrst_zero", o_zero, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("midrst_ready", o_ready, 1);
        repeat (25) @(posedge i_clk);
        #1;
        check("midrst_no_result", o_valid, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [5:0]   c;
            logic [W-1:0] a, b;
            c = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : codes[$urandom_range(0, 21)];
            a = pick_val();
            b = pick_val();
            ref_alu(c, a, b, er, ev, eil, elat);
            exec(c, a, b, $urandom_range(0, 2), r, v, z, il, lat, leak);
            check($sformatf("rnd%0d_c%h_result", i, c), r, er);
            check($sformatf("rnd%0d_c%h_ovf", i, c), v, ev);
            check($sformatf("rnd%0d_c%h_illegal", i, c), il, eil);
            check($sformatf("rnd%0d_c%h_zero", i, c), z, (er == 0));
            check($sformatf("rnd%0d_c%h_latency", i, c), lat, elat);
            check($sformatf("rnd%0d_c%h_ready_busy", i, c), leak, 0);
        end

        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
